// File: rtl/fft_pkg.sv
// Shared defaults and fill-state encoding for the FFT readout path.
package fft_pkg;

  localparam int FFT_WORD_W    = 32;
  localparam int FFT_NUM_WORDS = 32;

  typedef enum logic {FILL_IDLE, FILL_ACTIVE} fill_state_t;

endpackage

// File: rtl/fft_frame_packer.sv
// Collects FFT result words into a wide frame and hands it to the SPI path
// through a one-frame hold buffer with valid/ready and a sticky overflow flag.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int WORD_W    = FFT_WORD_W,
  parameter int NUM_WORDS = FFT_NUM_WORDS,
  parameter int MSB_FIRST = 1,
  localparam int FRAME_W  = WORD_W * NUM_WORDS,
  localparam int CNT_W    = $clog2(NUM_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_first,
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               overflow,
  output logic [CNT_W-1:0]   word_cnt
);

  fill_state_t        state, state_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_slot;
  logic               last;
  logic               hold_free;
  logic [WORD_W-1:0]  fill_buf  [NUM_WORDS];
  logic [WORD_W-1:0]  slot_word [NUM_WORDS];
  logic [FRAME_W-1:0] frame_next;

  // A first-marked word always restarts at slot 0, even mid-frame.
  always_comb begin
    wr_en      = in_valid && (in_first || (state == FILL_ACTIVE));
    wr_slot    = in_first ? '0 : word_cnt;
    last       = wr_en && (wr_slot == CNT_W'(NUM_WORDS - 1));
    hold_free  = !frame_valid || frame_ready;
    state_next = state;
    cnt_next   = word_cnt;
    if (wr_en) begin
      if (last) begin
        state_next = FILL_IDLE;
        cnt_next   = '0;
      end else begin
        state_next = FILL_ACTIVE;
        cnt_next   = wr_slot + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      word_cnt <= cnt_next;
    end
  end

  // The final word is merged combinationally so the frame completes on its own edge.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_slot
    localparam int LO = (MSB_FIRST != 0) ? FRAME_W - (g + 1) * WORD_W : g * WORD_W;

    always_ff @(posedge clk) begin
      if (reset) begin
        fill_buf[g] <= '0;
      end else if (wr_en && (wr_slot == CNT_W'(g))) begin
        fill_buf[g] <= in_word;
      end
    end

    assign slot_word[g]              = (wr_en && (wr_slot == CNT_W'(g))) ? in_word : fill_buf[g];
    assign frame_next[LO +: WORD_W]  = slot_word[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_out   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else if (last) begin
      if (hold_free) begin
        frame_out   <= frame_next;
        frame_valid <= 1'b1;
      end else begin
        overflow    <= 1'b1;
      end
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
